// File: rtl/tlb_maint_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : tlb_maint_ctrl_if
// Description : Request/response bundle between the pipeline and the TLB
//               maintenance controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface tlb_maint_ctrl_if #(
    parameter int IDX_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [4:0]       req_inv_op;
    logic [9:0]       req_asid;
    logic [31:0]      req_va;
    logic             resp_valid;
    logic             resp_hit;
    logic [IDX_W-1:0] resp_index;
    logic             busy;

    modport master (
        output req_valid, req_op, req_inv_op, req_asid, req_va,
        input  req_ready, resp_valid, resp_hit, resp_index, busy
    );

    modport slave (
        input  req_valid, req_op, req_inv_op, req_asid, req_va,
        output req_ready, resp_valid, resp_hit, resp_index, busy
    );
endinterface
`default_nettype wire

// File: rtl/tlb_maint_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tlb_maint_ctrl
// Description : Sequences tlbsrch/tlbrd/tlbwr/tlbfill/invtlb against the TLB,
//               arbitrates search port s1, walks entries for invtlb.
//               Define TLB_FILL_LFSR_EN to pick tlbfill victims with a 4-bit LFSR.
// Revision    : 1.0 - initial release
// ============================================================================
module tlb_maint_ctrl #(
    parameter int TLBNUM = 16,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              resetn,
    tlb_maint_ctrl_if.slave   bus,
    input  logic [IDX_W-1:0]  csr_tlbidx_index,
    input  logic [18:0]       csr_tlbehi_vppn,
    input  logic [9:0]        csr_asid,
    input  logic              exe_lookup_valid,
    input  logic [18:0]       exe_vppn,
    input  logic              exe_va_bit12,
    output logic              exe_grant,
    output logic [18:0]       s1_vppn,
    output logic              s1_va_bit12,
    output logic [9:0]        s1_asid,
    input  logic              s1_found,
    input  logic [IDX_W-1:0]  s1_index,
    output logic [IDX_W-1:0]  r_index,
    input  logic              r_e,
    input  logic              r_g,
    input  logic [9:0]        r_asid,
    input  logic [18:0]       r_vppn,
    input  logic [5:0]        r_ps,
    output logic              tlbrd_we,
    output logic              tlb_we,
    output logic [IDX_W-1:0]  tlb_w_index,
    output logic              tlb_w_e
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TLBNUM - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SRCH = 3'd1,
        S_RD   = 3'd2,
        S_WR   = 3'd3,
        S_FILL = 3'd4,
        S_INV  = 3'd5,
        S_RESP = 3'd6
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] fill_ctr_q, fill_ctr_d;
    logic             inv_hit_q, inv_hit_d;
    logic             resp_hit_q, resp_hit_d;
    logic [IDX_W-1:0] resp_index_q, resp_index_d;
    logic [4:0]       inv_op_q, inv_op_d;
    logic [9:0]       asid_q, asid_d;
    logic [18:0]      va_q, va_d;
    logic             va_m, asid_eq, inv_match;
    logic             req_ready_w, resp_valid_w;

`ifdef TLB_FILL_LFSR_EN
    localparam logic [IDX_W-1:0] FILL_SEED = IDX_W'(1);

    if (IDX_W != 4) begin : g_lfsr_width_chk
        $error("TLB_FILL_LFSR_EN requires IDX_W == 4");
    end

    // x^4 + x^3 + 1 Fibonacci LFSR: never reaches zero, so entry 0 is never a victim
    always_comb fill_ctr_d = {fill_ctr_q[IDX_W-2:0], fill_ctr_q[3] ^ fill_ctr_q[2]};
`else
    localparam logic [IDX_W-1:0] FILL_SEED = '0;

    always_comb fill_ctr_d = (fill_ctr_q == LAST_IDX) ? '0 : fill_ctr_q + IDX_W'(1);
`endif

    // invtlb per-entry match; huge pages compare only the upper VA bits
    always_comb begin
        va_m      = (r_ps == 6'd21) ? (r_vppn[18:9] == va_q[18:9]) : (r_vppn == va_q);
        asid_eq   = (r_asid == asid_q);
        inv_match = 1'b0;
        case (inv_op_q)
            5'd0, 5'd1: inv_match = 1'b1;
            5'd2:       inv_match = r_g;
            5'd3:       inv_match = !r_g;
            5'd4:       inv_match = !r_g && asid_eq;
            5'd5:       inv_match = !r_g && asid_eq && va_m;
            5'd6:       inv_match = (r_g || asid_eq) && va_m;
            default:    inv_match = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        inv_hit_d    = inv_hit_q;
        resp_hit_d   = resp_hit_q;
        resp_index_d = resp_index_q;
        inv_op_d     = inv_op_q;
        asid_d       = asid_q;
        va_d         = va_q;
        s1_vppn      = exe_vppn;
        s1_va_bit12  = exe_va_bit12;
        s1_asid      = csr_asid;
        exe_grant    = exe_lookup_valid && resetn;
        r_index      = csr_tlbidx_index;
        tlbrd_we     = 1'b0;
        tlb_we       = 1'b0;
        tlb_w_index  = csr_tlbidx_index;
        tlb_w_e      = 1'b0;
        resp_valid_w = 1'b0;
        req_ready_w  = resetn && (state_q == S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid && req_ready_w) begin
                    inv_op_d  = bus.req_inv_op;
                    asid_d    = bus.req_asid;
                    va_d      = bus.req_va[31:13];
                    inv_hit_d = 1'b0;
                    case (bus.req_op)
                        3'd0: state_d = S_SRCH;
                        3'd1: state_d = S_RD;
                        3'd2: state_d = S_WR;
                        3'd3: state_d = S_FILL;
                        3'd4: begin
                            if (bus.req_inv_op > 5'd6) begin
                                state_d    = S_RESP;
                                resp_hit_d = 1'b0;
                            end else begin
                                state_d = S_INV;
                            end
                        end
                        default: begin
                            state_d    = S_RESP;
                            resp_hit_d = 1'b0;
                        end
                    endcase
                end
            end
            S_SRCH: begin
                s1_vppn      = csr_tlbehi_vppn;
                s1_va_bit12  = 1'b0;
                s1_asid      = csr_asid;
                exe_grant    = 1'b0;
                resp_hit_d   = s1_found;
                resp_index_d = s1_index;
                state_d      = S_RESP;
            end
            S_RD: begin
                tlbrd_we   = resetn;
                resp_hit_d = 1'b0;
                state_d    = S_RESP;
            end
            S_WR: begin
                tlb_we     = resetn;
                tlb_w_e    = 1'b1;
                resp_hit_d = 1'b0;
                state_d    = S_RESP;
            end
            S_FILL: begin
                tlb_we       = resetn;
                tlb_w_index  = fill_ctr_q;
                tlb_w_e      = 1'b1;
                resp_hit_d   = 1'b0;
                resp_index_d = fill_ctr_q;
                state_d      = S_RESP;
            end
            S_INV: begin
                r_index     = ptr_q;
                tlb_w_index = ptr_q;
                if (r_e && inv_match) begin
                    tlb_we    = resetn;
                    inv_hit_d = 1'b1;
                end
                if (ptr_q == LAST_IDX) begin
                    ptr_d      = '0;
                    resp_hit_d = inv_hit_d;
                    state_d    = S_RESP;
                end else begin
                    ptr_d = ptr_q + IDX_W'(1);
                end
            end
            S_RESP: begin
                resp_valid_w = resetn;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            fill_ctr_q   <= FILL_SEED;
            inv_hit_q    <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_index_q <= '0;
            inv_op_q     <= '0;
            asid_q       <= '0;
            va_q         <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            fill_ctr_q   <= fill_ctr_d;
            inv_hit_q    <= inv_hit_d;
            resp_hit_q   <= resp_hit_d;
            resp_index_q <= resp_index_d;
            inv_op_q     <= inv_op_d;
            asid_q       <= asid_d;
            va_q         <= va_d;
        end
    end

    assign bus.req_ready  = req_ready_w;
    assign bus.resp_valid = resp_valid_w;
    assign bus.resp_hit   = resp_hit_q;
    assign bus.resp_index = resp_index_q;
    assign bus.busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_tlb_maint_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tlb_maint_ctrl
// Description : Scoreboard bench for tlb_maint_ctrl with a behavioural TLB.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tlb_maint_ctrl;
    localparam int TLBNUM = 16;
    localparam int IDX_W  = 4;
`ifdef TLB_FILL_LFSR_EN
    localparam logic [IDX_W-1:0] FILL_RST = 4'd1;
    localparam logic [IDX_W-1:0] FILL_EXP = 4'd5;   // LFSR state following 4'b1010
`else
    localparam logic [IDX_W-1:0] FILL_RST = 4'd0;
    localparam logic [IDX_W-1:0] FILL_EXP = 4'd11;
`endif

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    tlb_maint_ctrl_if #(.IDX_W(IDX_W)) bus ();

    logic [IDX_W-1:0] csr_tlbidx_index;
    logic [18:0]      csr_tlbehi_vppn;
    logic [9:0]       csr_asid;
    logic             exe_lookup_valid, exe_va_bit12, exe_grant;
    logic [18:0]      exe_vppn, s1_vppn;
    logic             s1_va_bit12, s1_found;
    logic [9:0]       s1_asid;
    logic [IDX_W-1:0] s1_index, r_index, tlb_w_index;
    logic             r_e, r_g, tlbrd_we, tlb_we, tlb_w_e;
    logic [9:0]       r_asid;
    logic [18:0]      r_vppn;
    logic [5:0]       r_ps;

    tlb_maint_ctrl #(.TLBNUM(TLBNUM), .IDX_W(IDX_W)) dut (
        .clk(clk), .resetn(resetn), .bus(bus),
        .csr_tlbidx_index(csr_tlbidx_index), .csr_tlbehi_vppn(csr_tlbehi_vppn),
        .csr_asid(csr_asid), .exe_lookup_valid(exe_lookup_valid), .exe_vppn(exe_vppn),
        .exe_va_bit12(exe_va_bit12), .exe_grant(exe_grant), .s1_vppn(s1_vppn),
        .s1_va_bit12(s1_va_bit12), .s1_asid(s1_asid), .s1_found(s1_found),
        .s1_index(s1_index), .r_index(r_index), .r_e(r_e), .r_g(r_g), .r_asid(r_asid),
        .r_vppn(r_vppn), .r_ps(r_ps), .tlbrd_we(tlbrd_we), .tlb_we(tlb_we),
        .tlb_w_index(tlb_w_index), .tlb_w_e(tlb_w_e)
    );

    // Behavioural TLB
    logic             m_e    [TLBNUM];
    logic             m_g    [TLBNUM];
    logic [9:0]       m_asid [TLBNUM];
    logic [18:0]      m_vppn [TLBNUM];
    logic [5:0]       m_ps   [TLBNUM];
    logic             set_we = 1'b0;
    logic [IDX_W-1:0] set_idx;
    logic             set_e, set_g;
    logic [9:0]       set_asid;
    logic [18:0]      set_vppn;
    logic [5:0]       set_ps;

    always @(posedge clk) begin
        if (set_we) begin
            m_e[set_idx]    <= set_e;
            m_g[set_idx]    <= set_g;
            m_asid[set_idx] <= set_asid;
            m_vppn[set_idx] <= set_vppn;
            m_ps[set_idx]   <= set_ps;
        end
        if (tlb_we === 1'b1) m_e[tlb_w_index] <= tlb_w_e;
    end

    always_comb begin
        s1_found = 1'b0;
        s1_index = '0;
        for (int i = 0; i < TLBNUM; i++) begin
            if (m_e[i] === 1'b1 && m_vppn[i] == s1_vppn && (m_g[i] || m_asid[i] == s1_asid)) begin
                s1_found = 1'b1;
                s1_index = IDX_W'(i);
            end
        end
    end

    assign r_e    = m_e[r_index];
    assign r_g    = m_g[r_index];
    assign r_asid = m_asid[r_index];
    assign r_vppn = m_vppn[r_index];
    assign r_ps   = m_ps[r_index];

    // Reference victim counter and cycle count
    function automatic logic [IDX_W-1:0] fill_next(input logic [IDX_W-1:0] v);
`ifdef TLB_FILL_LFSR_EN
        return {v[2:0], v[3] ^ v[2]};
`else
        return (v == 4'd15) ? 4'd0 : v + 4'd1;
`endif
    endfunction

    logic [IDX_W-1:0] fill_m;
    int               cyc = 0;
    always @(posedge clk) begin
        fill_m <= !resetn ? FILL_RST : fill_next(fill_m);
        cyc    <= cyc + 1;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard
    typedef struct {
        int               due;
        bit               ch_hit;
        bit               hit;
        bit               ch_idx;
        logic [IDX_W-1:0] idx;
    } resp_t;

    typedef struct {
        int               due;
        logic [IDX_W-1:0] idx;
        bit               e;
    } wr_t;

    resp_t resp_q[$];
    wr_t   wr_q[$];
    int    rd_cnt = 0;

    always @(negedge clk) begin : mon_resp
        resp_t r;
        if (bus.resp_valid === 1'b1) begin
            if (resp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL resp_unexpected: resp_valid=1 at cycle %0d, want 0", cyc);
            end else begin
                r = resp_q.pop_front();
                chk("resp_cycle", 32'(cyc), 32'(r.due));
                if (r.ch_hit) chk("resp_hit", 32'(bus.resp_hit), 32'(r.hit));
                if (r.ch_idx) chk("resp_index", 32'(bus.resp_index), 32'(r.idx));
            end
        end
    end

    always @(negedge clk) begin : mon_wr
        wr_t w;
        if (tlb_we === 1'b1) begin
            if (wr_q.size() == 0) begin
                total++; bad++;
                $display("FAIL wr_unexpected: tlb_we=1 idx=%0d at cycle %0d, want 0", tlb_w_index, cyc);
            end else begin
                w = wr_q.pop_front();
                chk("wr_cycle", 32'(cyc), 32'(w.due));
                chk("wr_index", 32'(tlb_w_index), 32'(w.idx));
                chk("wr_e", 32'(tlb_w_e), 32'(w.e));
            end
        end
    end

    always @(negedge clk) if (tlbrd_we === 1'b1) rd_cnt <= rd_cnt + 1;

    // Stimulus helpers; inputs change 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_entry(input int i, input bit e, input bit g, input logic [9:0] asid,
                             input logic [18:0] vppn, input logic [5:0] ps);
        set_we = 1'b1; set_idx = IDX_W'(i); set_e = e; set_g = g;
        set_asid = asid; set_vppn = vppn; set_ps = ps;
        step();
        set_we = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (bus.req_ready !== 1'b1 && n < 100) begin step(); n++; end
        if (bus.req_ready !== 1'b1) begin
            total++; bad++;
            $display("FAIL ready_timeout: req_ready=%b, want 1", bus.req_ready);
        end
    endtask

    task automatic fire(input logic [2:0] op, input logic [4:0] iop, input logic [9:0] asid,
                        input logic [31:0] va);
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_inv_op = iop;
        bus.req_asid = asid; bus.req_va = va;
        step();
        bus.req_valid = 1'b0;
    endtask

    task automatic exp_resp(input int due, input bit ch_hit, input bit hit, input bit ch_idx,
                            input logic [IDX_W-1:0] idx);
        resp_t r;
        r.due = due; r.ch_hit = ch_hit; r.hit = hit; r.ch_idx = ch_idx; r.idx = idx;
        resp_q.push_back(r);
    endtask

    task automatic exp_wr(input int due, input logic [IDX_W-1:0] idx, input bit e);
        wr_t w;
        w.due = due; w.idx = idx; w.e = e;
        wr_q.push_back(w);
    endtask

    task automatic drain();
        int n = 0;
        while ((resp_q.size() != 0 || wr_q.size() != 0) && n < 100) begin step(); n++; end
        if (resp_q.size() != 0 || wr_q.size() != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout: pending resp=%0d wr=%0d, want 0/0", resp_q.size(), wr_q.size());
            resp_q.delete();
            wr_q.delete();
        end
        step();
        step();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int a;
        int n;
        int rd0;
        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_inv_op = '0;
        bus.req_asid = '0; bus.req_va = '0;
        csr_tlbidx_index = '0; csr_tlbehi_vppn = '0; csr_asid = '0;
        exe_lookup_valid = 1'b0; exe_vppn = '0; exe_va_bit12 = 1'b0;

        // Reset while clearing the TLB
        for (int i = 0; i < TLBNUM; i++) set_entry(i, 1'b0, 1'b0, 10'd0, 19'(i), 6'd12);
        chk("rst_req_ready", 32'(bus.req_ready), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 0);
        chk("rst_resp_hit", 32'(bus.resp_hit), 0);
        chk("rst_resp_index", 32'(bus.resp_index), 0);
        chk("rst_tlb_we", 32'(tlb_we), 0);
        resetn = 1'b1;
        #1;
        chk("rel_req_ready", 32'(bus.req_ready), 1);

        // FILL accepted in cycle 10 after reset
        n = 0;
        while (fill_m != 4'd10 && n < 40) begin step(); n++; end
        wait_ready();
        a = cyc + 1;
        exp_wr(a, FILL_EXP, 1'b1);
        exp_resp(a + 1, 1'b0, 1'b0, 1'b1, FILL_EXP);
        fire(3'd3, 5'd0, 10'd0, 32'd0);
        drain();

        set_entry(7, 1'b1, 1'b0, 10'd5, 19'h12345, 6'd12);
        set_entry(1, 1'b1, 1'b0, 10'd2, 19'h00201, 6'd12);
        set_entry(4, 1'b1, 1'b1, 10'd9, 19'h00201, 6'd12);
        set_entry(5, 1'b1, 1'b0, 10'd2, 19'h003FF, 6'd21);

        // SRCH hit on entry 7 while EXE requests s1
        csr_tlbehi_vppn = 19'h12345; csr_asid = 10'd5;
        exe_lookup_valid = 1'b1; exe_vppn = 19'h0ABCD; exe_va_bit12 = 1'b1;
        wait_ready();
        #1;
        chk("idle_exe_grant", 32'(exe_grant), 1);
        a = cyc + 1;
        exp_resp(a + 1, 1'b1, 1'b1, 1'b1, 4'd7);
        fire(3'd0, 5'd0, 10'd0, 32'd0);
        chk("srch_exe_grant", 32'(exe_grant), 0);
        chk("srch_s1_vppn", 32'(s1_vppn), 32'h12345);
        chk("srch_s1_asid", 32'(s1_asid), 5);
        chk("srch_s1_bit12", 32'(s1_va_bit12), 0);
        step();
        chk("resp_exe_grant", 32'(exe_grant), 1);
        chk("resp_req_ready", 32'(bus.req_ready), 0);
        chk("resp_s1_vppn", 32'(s1_vppn), 32'h0ABCD);
        drain();
        exe_lookup_valid = 1'b0;

        // RD index 3
        csr_tlbidx_index = 4'd3;
        wait_ready();
        rd0 = rd_cnt;
        a = cyc + 1;
        exp_resp(a + 1, 1'b0, 1'b0, 1'b0, 4'd0);
        fire(3'd1, 5'd0, 10'd0, 32'd0);
        chk("rd_r_index", 32'(r_index), 3);
        chk("rd_tlbrd_we", 32'(tlbrd_we), 1);
        drain();
        chk("rd_pulses", 32'(rd_cnt - rd0), 1);

        // WR index 3
        wait_ready();
        a = cyc + 1;
        exp_wr(a, 4'd3, 1'b1);
        exp_resp(a + 1, 1'b0, 1'b0, 1'b0, 4'd0);
        fire(3'd2, 5'd0, 10'd0, 32'd0);
        drain();

        // INV op 5: clears entry 1 (4K page) and entry 5 (huge page), keeps global entry 4
        csr_asid = 10'd7;
        wait_ready();
        a = cyc + 1;
        exp_wr(a + 1, 4'd1, 1'b0);
        exp_wr(a + 5, 4'd5, 1'b0);
        exp_resp(a + 16, 1'b1, 1'b1, 1'b0, 4'd0);
        fire(3'd4, 5'd5, 10'd2, 32'h0040_2000);
        drain();
        chk("inv5_e1_cleared", 32'(m_e[1]), 0);
        chk("inv5_e4_kept", 32'(m_e[4]), 1);

        // Reserved op 6 answers next cycle with no hit
        wait_ready();
        a = cyc + 1;
        exp_resp(a, 1'b1, 1'b0, 1'b0, 4'd0);
        fire(3'd6, 5'd0, 10'd0, 32'd0);
        drain();

        // INV op 2: global entries only
        wait_ready();
        a = cyc + 1;
        exp_wr(a + 4, 4'd4, 1'b0);
        exp_resp(a + 16, 1'b1, 1'b1, 1'b0, 4'd0);
        fire(3'd4, 5'd2, 10'd0, 32'd0);
        drain();

        // INV op 7 is illegal: immediate response, no writes
        wait_ready();
        a = cyc + 1;
        exp_resp(a, 1'b1, 1'b0, 1'b0, 4'd0);
        fire(3'd4, 5'd7, 10'd0, 32'd0);
        drain();

        // Reset in the middle of an invalidate-all walk
        for (int i = 0; i < TLBNUM; i++) set_entry(i, 1'b1, 1'b0, 10'd0, 19'(i), 6'd12);
        wait_ready();
        a = cyc + 1;
        for (int p = 0; p < 8; p++) exp_wr(a + p, IDX_W'(p), 1'b0);
        fire(3'd4, 5'd1, 10'd0, 32'd0);
        repeat (8) step();
        resetn = 1'b0;
        #1;
        chk("walk_rst_tlb_we", 32'(tlb_we), 0);
        chk("walk_rst_ready", 32'(bus.req_ready), 0);
        step();
        step();
        resetn = 1'b1;
        #1;
        chk("post_rst_ready", 32'(bus.req_ready), 1);
        chk("post_rst_busy", 32'(bus.busy), 0);
        drain();
        for (int i = 0; i < TLBNUM; i++)
            chk($sformatf("walk_entry%0d_e", i), 32'(m_e[i]), (i >= 8) ? 1 : 0);

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
